clock_frequency_divider: RTL and testbench
==========================================

// Module: clock_frequency_divider
// PURPOSE
//   Derives a slow, 50%-duty clock from the board clock by counting input cycles and toggling.
//   Used by the chess board logic to pace cursor movement and lock/move handling.
//   The chess logic instantiates it with OUTPUT_FREQUENCY=10, giving a 10 Hz tick from 50 MHz.
//   OutClock is a fabric-generated clock. Consumers may use it as a clock edge.
// PARAMETERS
//   INPUT_FREQUENCY   50_000_000  frequency of InClock in Hz
//   OUTPUT_FREQUENCY  1           requested OutClock frequency in Hz; must be > 0
//   HALF_PERIOD       derived localparam, = INPUT_FREQUENCY / (2*OUTPUT_FREQUENCY), integer-truncated
//   COUNT_WIDTH       derived localparam, = max(1, $clog2(HALF_PERIOD))
// PORTS
//   InClock   in   1            source clock; all logic on its rising edge
//   reset     in   1            asynchronous, active-high reset
//   OutClock  out  1            divided clock, registered
// BEHAVIOUR
//   Interface
//   - One clock (InClock).
//   - reset is asynchronous and active-high.
//   Elaboration checks
//   - Fail elaboration (generate-time $error or equivalent) if OUTPUT_FREQUENCY == 0.
//   - Fail elaboration if 2*OUTPUT_FREQUENCY > INPUT_FREQUENCY, i.e. HALF_PERIOD < 1.
//   Reset
//   - While reset=1: counter = 0 and OutClock = 0, immediately, independent of InClock.
//   Counting, per InClock rising edge with reset=0
//   - counter != HALF_PERIOD-1: counter <= counter + 1; OutClock holds.
//   - counter == HALF_PERIOD-1: counter <= 0; OutClock <= ~OutClock.
//   Timing after reset release
//   - First OutClock rise: at the HALF_PERIOD-th InClock rising edge.
//   - First fall: at the 2*HALF_PERIOD-th edge.
//   - Period = 2*HALF_PERIOD input cycles; high and low phases exactly HALF_PERIOD cycles each.
//   Boundary cases
//   - HALF_PERIOD == 1: OutClock toggles every InClock edge (Fin/2). Counter stays 0.
//   - Non-integer ratio: truncation gives a frequency slightly above request; no dithering.
//   - Wrap: counter never exceeds HALF_PERIOD-1; no overflow for any legal parameter set.
//   - Reset mid-period: abort the phase. OutClock drops to 0 at once (may shorten a high pulse).
//     Counting restarts from 0 on release.
//   - Reset deasserted coincident with an InClock edge: that edge counts as edge 0 (no increment).
//   - Counter and OutClock are plain registers. No other outputs, no enable, no glitches on OutClock.
// TESTING
//   - T1 reset: INPUT_FREQUENCY=100, OUTPUT_FREQUENCY=10 (HALF_PERIOD=5).
//     Assert reset -> OutClock=0 before any InClock edge.
//   - T2 period: same params, release reset -> OutClock rises on edge 5, falls on 10, rises on 15.
//     Duty 5/5.
//   - T3 minimum divide: INPUT=20, OUTPUT=10 (HALF_PERIOD=1) -> OutClock toggles every InClock edge.
//   - T4 truncation: INPUT=100, OUTPUT=15 (HALF_PERIOD=3) -> period 6 input cycles.
//   - T5 mid-period reset: HALF_PERIOD=5, pulse reset at edge 7 while OutClock=1
//     -> OutClock=0 at once. After release, next rise on 5th edge.
//   - T6 defaults with OUTPUT_FREQUENCY=10 (HALF_PERIOD=2_500_000): first rise at edge 2_500_000.
//     Counter width 22 bits. Illegal OUTPUT_FREQUENCY=0 must fail elaboration.

Source files
------------

// File: rtl/clock_frequency_divider.sv
// clock_frequency_divider
//   Derives a slow, 50%-duty clock from InClock by counting HALF_PERIOD input
//   cycles per phase and toggling the output register at the end of each phase.
//
// Parameters
//   INPUT_FREQUENCY   frequency of InClock in Hz
//   OUTPUT_FREQUENCY  requested OutClock frequency in Hz (> 0)
//
// Ports
//   InClock   in   source clock; all state changes on its rising edge
//   reset     in   asynchronous, active-high reset; clears counter and OutClock
//   OutClock  out  divided clock, driven straight from a register (glitch-free)

module clock_frequency_divider #(
    parameter int unsigned INPUT_FREQUENCY  = 50_000_000,
    parameter int unsigned OUTPUT_FREQUENCY = 1
) (
    input  logic InClock,
    input  logic reset,
    output logic OutClock
);

    // Guard the division so an illegal OUTPUT_FREQUENCY reaches the check below
    // instead of tripping a divide-by-zero during elaboration.
    localparam int unsigned HALF_PERIOD =
        (OUTPUT_FREQUENCY == 0) ? 0 : INPUT_FREQUENCY / (2 * OUTPUT_FREQUENCY);

    // The counter only has to reach HALF_PERIOD-1, so clog2(HALF_PERIOD) bits suffice.
    localparam int unsigned COUNT_WIDTH = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT =
        (HALF_PERIOD > 0) ? COUNT_WIDTH'(HALF_PERIOD - 1) : '0;

    // Elaboration-time parameter checks
    if (OUTPUT_FREQUENCY == 0) begin : g_bad_output_frequency
        $error("clock_frequency_divider: OUTPUT_FREQUENCY must be greater than 0");
    end else if (HALF_PERIOD < 1) begin : g_bad_ratio
        $error("clock_frequency_divider: 2*OUTPUT_FREQUENCY exceeds INPUT_FREQUENCY");
    end

    logic [COUNT_WIDTH-1:0] counter_q, counter_d;
    logic                   out_q, out_d;
    logic                   phase_end;

    assign phase_end = (counter_q == LAST_COUNT);

    always_comb begin
        counter_d = counter_q + COUNT_WIDTH'(1);
        out_d     = out_q;
        if (phase_end) begin
            counter_d = '0;
            out_d     = ~out_q;
        end
    end

    always_ff @(posedge InClock or posedge reset) begin
        if (reset) begin
            counter_q <= '0;
            out_q     <= 1'b0;
        end else begin
            counter_q <= counter_d;
            out_q     <= out_d;
        end
    end

    assign OutClock = out_q;

endmodule

// File: tb/tb_clock_frequency_divider.sv
module tb_clock_frequency_divider;

    logic clk;
    logic rst;
    logic out_hp5;
    logic out_hp1;
    logic out_hp3;
    logic out_big;

    int checks;
    int failures;

    // HALF_PERIOD = 5
    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dut_hp5 (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_hp5)
    );

    // HALF_PERIOD = 1
    clock_frequency_divider #(.INPUT_FREQUENCY(20), .OUTPUT_FREQUENCY(10)) dut_hp1 (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_hp1)
    );

    // 100/30 truncates to HALF_PERIOD = 3
    clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(15)) dut_hp3 (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_hp3)
    );

    // Default input frequency, HALF_PERIOD = 2_500_000
    clock_frequency_divider #(.OUTPUT_FREQUENCY(10)) dut_big (
        .InClock (clk),
        .reset   (rst),
        .OutClock(out_big)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp5, exp1, exp3;
        checks   = 0;
        failures = 0;
        rst      = 1'b0;

        // T1: reset clears the output before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("t1_reset_hp5", out_hp5, 1'b0);
        chk("t1_reset_hp1", out_hp1, 1'b0);
        chk("t1_reset_hp3", out_hp3, 1'b0);
        chk("t1_reset_big", out_big, 1'b0);

        // Hold reset across an edge, then release between edges
        tick();
        chk("t1_reset_held", out_hp5, 1'b0);
        rst = 1'b0;

        // T2/T3/T4: edge n after release -> output = (n / HALF_PERIOD) odd
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp5 = ((n / 5) % 2) == 1;
            exp1 = (n % 2) == 1;
            exp3 = ((n / 3) % 2) == 1;
            chk($sformatf("t2_hp5_edge%0d", n), out_hp5, exp5);
            chk($sformatf("t3_hp1_edge%0d", n), out_hp1, exp1);
            chk($sformatf("t4_hp3_edge%0d", n), out_hp3, exp3);
        end

        // T6: large divider has not toggled after a handful of edges
        chk("t6_big_low", out_big, 1'b0);

        // T5: mid-period reset while the HALF_PERIOD=5 output is high
        rst = 1'b1;
        #1;
        chk("t5_pre_reset", out_hp5, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 7; n++) tick();
        chk("t5_high_at_edge7", out_hp5, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_drop_hp5", out_hp5, 1'b0);
        chk("t5_async_drop_hp3", out_hp3, 1'b0);
        tick();
        chk("t5_held_low", out_hp5, 1'b0);
        rst = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            exp5 = ((n / 5) % 2) == 1;
            chk($sformatf("t5_restart_edge%0d", n), out_hp5, exp5);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
